// File: rtl/pulse_width_meter.sv
// rtl/pulse_width_meter.sv - multi-channel pulse-width meter with glitch rejection and idle timeout
//
// Each channel synchronises its input and samples it on a shared prescaled
// tick. It counts the high time in ticks and publishes the width on the falling
// edge. After a long enough idle period the output reverts to DEFAULT_OUT.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   vin        asynchronous pulse inputs, bit i = channel i
//   width_out  channel i width at [i*WIDTH +: WIDTH]
//   valid      one-cycle strobe per channel when width_out[i] is updated
//   sat        sticky per channel: last published width saturated
//   stale      per channel: timed out, width_out holds DEFAULT_OUT
module pulse_width_meter #(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 13,
    parameter int PRESCALE    = 100,
    parameter int DEFAULT_OUT = 300,
    parameter int MIN_WIDTH   = 2,
    parameter int TIMEOUT     = 4095
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS-1:0]          vin,
    output logic [CHANNELS*WIDTH-1:0]    width_out,
    output logic [CHANNELS-1:0]          valid,
    output logic [CHANNELS-1:0]          sat,
    output logic [CHANNELS-1:0]          stale
);

    localparam int               PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    P_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] DEF_W  = WIDTH'(DEFAULT_OUT);
    localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_WIDTH);
    localparam logic [WIDTH-1:0] MAX_W  = '1;
    localparam logic [15:0]      TMO    = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1
    } state_t;

    // Two-flop synchroniser; the channel FSMs only ever look at vs.
    logic [CHANNELS-1:0] vs_meta;
    logic [CHANNELS-1:0] vs;

    always_ff @(posedge clk) begin
        if (reset) begin
            vs_meta <= '0;
            vs      <= '0;
        end else begin
            vs_meta <= vin;
            vs      <= vs_meta;
        end
    end

    // Shared sample tick: high for the single cycle where the count sits at PRESCALE-1.
    logic [PW-1:0] pcnt;
    logic          tick;

    assign tick = (pcnt == P_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           state;
        logic [WIDTH-1:0] width;
        logic [WIDTH-1:0] out_r;
        logic [15:0]      idle_cnt;
        logic             ovf;
        logic             valid_r;
        logic             sat_r;
        logic             stale_r;

        always_ff @(posedge clk) begin
            if (reset) begin
                state    <= IDLE;
                width    <= '0;
                idle_cnt <= '0;
                ovf      <= 1'b0;
                out_r    <= DEF_W;
                valid_r  <= 1'b0;
                sat_r    <= 1'b0;
                stale_r  <= 1'b0;
            end else begin
                valid_r <= 1'b0;
                case (state)
                    IDLE: begin
                        if (tick) begin
                            if (vs[i]) begin
                                state    <= COUNT;
                                width    <= {{(WIDTH-1){1'b0}}, 1'b1};
                                idle_cnt <= '0;
                                ovf      <= 1'b0;
                            end else if (idle_cnt != TMO) begin
                                idle_cnt <= idle_cnt + 16'd1;
                                // Fires only on the transition into TIMEOUT, so a long idle gives one strobe.
                                if (idle_cnt == TMO - 16'd1) begin
                                    out_r   <= DEF_W;
                                    stale_r <= 1'b1;
                                    valid_r <= 1'b1;
                                end
                            end
                        end
                    end
                    COUNT: begin
                        if (tick) begin
                            if (vs[i]) begin
                                if (width == MAX_W) begin
                                    ovf <= 1'b1;
                                end else begin
                                    width <= width + 1'b1;
                                end
                            end else begin
                                // Short highs are glitches: leave every output untouched.
                                if (width >= MIN_W) begin
                                    out_r   <= width;
                                    valid_r <= 1'b1;
                                    sat_r   <= ovf;
                                    stale_r <= 1'b0;
                                    ovf     <= 1'b0;
                                end
                                state    <= IDLE;
                                idle_cnt <= '0;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        width <= '0;
                    end
                endcase
            end
        end

        assign width_out[i*WIDTH +: WIDTH] = out_r;
        assign valid[i]                    = valid_r;
        assign sat[i]                      = sat_r;
        assign stale[i]                    = stale_r;
    end

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb/tb_pulse_width_meter.sv - self-checking bench for pulse_width_meter
module tb_pulse_width_meter;

    localparam int CH   = 2;
    localparam int W    = 6;
    localparam int P    = 4;
    localparam int DEF  = 300;
    localparam int MINW = 2;
    localparam int TMO  = 8;
    localparam int WMAX = (1 << W) - 1;
    localparam int DEFT = DEF % (1 << W);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [CH-1:0]     vin = '0;
    logic [CH*W-1:0]   width_out;
    logic [CH-1:0]     valid;
    logic [CH-1:0]     sat;
    logic [CH-1:0]     stale;

    pulse_width_meter #(
        .CHANNELS(CH), .WIDTH(W), .PRESCALE(P),
        .DEFAULT_OUT(DEF), .MIN_WIDTH(MINW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .vin(vin),
        .width_out(width_out), .valid(valid), .sat(sat), .stale(stale)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: cycle-accurate sync delay and tick phase, channel
    // behaviour expressed as run lengths of high and low samples.
    int            m_cnt;
    logic [CH-1:0] m_s1, m_s2;
    int            hrun [CH];
    int            lrun [CH];
    int            e_w  [CH];
    logic [CH-1:0] e_valid, e_sat, e_stale;
    logic [CH*W-1:0] e_vec;

    int   vcount [CH];
    int   last_w [CH];
    logic both_seen;

    task automatic tick_channel(input int i, input logic s);
        if (s) begin
            hrun[i]++;
        end else if (hrun[i] > 0) begin
            if (hrun[i] >= MINW) begin
                e_w[i]     = (hrun[i] > WMAX) ? WMAX : hrun[i];
                e_sat[i]   = (hrun[i] > WMAX);
                e_stale[i] = 1'b0;
                e_valid[i] = 1'b1;
            end
            hrun[i] = 0;
            lrun[i] = 0;
        end else if (lrun[i] < TMO) begin
            lrun[i]++;
            if (lrun[i] == TMO) begin
                e_w[i]     = DEFT;
                e_stale[i] = 1'b1;
                e_valid[i] = 1'b1;
            end
        end
    endtask

    task automatic model_edge();
        e_valid = '0;
        if (reset) begin
            m_cnt = 0;
            m_s1  = '0;
            m_s2  = '0;
            e_sat = '0;
            e_stale = '0;
            for (int i = 0; i < CH; i++) begin
                hrun[i] = 0;
                lrun[i] = 0;
                e_w[i]  = DEFT;
            end
        end else begin
            if (m_cnt == P - 1) begin
                for (int i = 0; i < CH; i++) tick_channel(i, m_s2[i]);
            end
            m_s2  = m_s1;
            m_s1  = vin;
            m_cnt = (m_cnt + 1) % P;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < CH; i++) e_vec[i*W +: W] = W'(e_w[i]);
        checks++;
        assert (valid === e_valid) else begin
            errors++;
            $error("FAIL valid: observed %b expected %b", valid, e_valid);
        end
        checks++;
        assert (width_out === e_vec) else begin
            errors++;
            $error("FAIL width_out: observed %h expected %h", width_out, e_vec);
        end
        checks++;
        assert (sat === e_sat) else begin
            errors++;
            $error("FAIL sat: observed %b expected %b", sat, e_sat);
        end
        checks++;
        assert (stale === e_stale) else begin
            errors++;
            $error("FAIL stale: observed %b expected %b", stale, e_stale);
        end
        for (int i = 0; i < CH; i++) begin
            if (valid[i]) begin
                vcount[i]++;
                last_w[i] = int'(width_out[i*W +: W]);
            end
        end
        if (valid == 2'b11) both_seen = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_counts();
        for (int i = 0; i < CH; i++) vcount[i] = 0;
        both_seen = 1'b0;
    endtask

    task automatic expect_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    int k1, k2;

    initial begin
        for (int i = 0; i < CH; i++) begin
            last_w[i] = -1;
            vcount[i] = 0;
        end
        both_seen = 1'b0;

        // Reset state
        reset = 1'b1;
        run(3);
        reset = 1'b0;
        expect_int("reset_w0", int'(width_out[0 +: W]), DEFT);
        expect_int("reset_w1", int'(width_out[W +: W]), DEFT);
        expect_int("reset_valid", int'(valid), 0);
        expect_int("reset_flags", int'({sat, stale}), 0);
        run($urandom_range(0, 3));

        // 5-tick pulse on ch0
        clear_counts();
        vin[0] = 1'b1;
        run(20);
        vin[0] = 1'b0;
        run(8);
        expect_int("pulse5_count", vcount[0], 1);
        expect_int("pulse5_width", last_w[0], 5);
        expect_int("pulse5_sat", int'(sat[0]), 0);
        expect_int("pulse5_ch1_out", int'(width_out[W +: W]), DEFT);

        // 1-tick glitch on ch0
        clear_counts();
        vin[0] = 1'b1;
        run(4);
        vin[0] = 1'b0;
        run(8);
        expect_int("glitch_count", vcount[0], 0);
        expect_int("glitch_hold", int'(width_out[0 +: W]), 5);

        // Saturating pulse on ch1, then a short one
        run($urandom_range(0, 3));
        vin[1] = 1'b1;
        run(280);
        vin[1] = 1'b0;
        run(8);
        expect_int("satur_width", last_w[1], WMAX);
        expect_int("satur_flag", int'(sat[1]), 1);
        vin[1] = 1'b1;
        run(12);
        vin[1] = 1'b0;
        run(8);
        expect_int("after_sat_width", int'(width_out[W +: W]), 3);
        expect_int("after_sat_flag", int'(sat[1]), 0);

        // Timeout on ch0 after a measurement, then recovery
        vin[0] = 1'b1;
        run(12);
        vin[0] = 1'b0;
        run(8);
        clear_counts();
        run(36);
        expect_int("timeout_count", vcount[0], 1);
        expect_int("timeout_width", int'(width_out[0 +: W]), DEFT);
        expect_int("timeout_stale", int'(stale[0]), 1);
        vin[0] = 1'b1;
        run(16);
        vin[0] = 1'b0;
        run(8);
        expect_int("recover_width", int'(width_out[0 +: W]), 4);
        expect_int("recover_stale", int'(stale[0]), 0);

        // Reset in the middle of COUNT on both channels
        vin = 2'b11;
        run(12 + $urandom_range(0, 3));
        reset = 1'b1;
        step();
        reset = 1'b0;
        expect_int("midreset_valid", int'(valid), 0);
        expect_int("midreset_w", int'(width_out), int'({W'(DEFT), W'(DEFT)}));
        expect_int("midreset_flags", int'({sat, stale}), 0);
        run(10);
        vin = 2'b00;
        run(8);

        // Simultaneous fall on both channels
        k1 = int'($urandom_range(1, 4));
        k2 = int'($urandom_range(2, 6));
        clear_counts();
        vin[0] = 1'b1;
        run(4 * k1);
        vin[1] = 1'b1;
        run(4 * k2);
        vin = 2'b00;
        run(8);
        expect_int("both_same_cycle", int'(both_seen), 1);
        expect_int("both_w0", last_w[0], k1 + k2);
        expect_int("both_w1", last_w[1], k2);

        // Random toggling on both channels against the model
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < CH; i++) begin
                if ($urandom_range(0, 9) == 0) vin[i] = ~vin[i];
            end
            step();
        end
        vin = '0;
        run(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
